// File: rtl/jtag_led_ctrl.sv
// LED controller behind a JTAG user data register. Frames carry data, an opcode
// and an even-parity bit; the capture path returns led state plus sticky status.
module jtag_led_ctrl #(
    parameter int                  NUM_LEDS       = 4,
    parameter bit                  LED_ACTIVE_LOW = 1'b1,
    parameter logic [NUM_LEDS-1:0] RESET_PATTERN  = '0
) (
    input  logic                jtag_tck,
    input  logic                rst_n,
    input  logic                jtag_sel,
    input  logic                jtag_capture,
    input  logic                jtag_shift,
    input  logic                jtag_update,
    input  logic                jtag_tdi,
    output logic                jtag_tdo,
    output logic [NUM_LEDS-1:0] led
);
    localparam int L  = NUM_LEDS + 3;
    localparam int CW = $clog2(L + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(L);
    localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

    logic [L-1:0]        sr;
    logic [CW-1:0]       cnt;
    logic [NUM_LEDS-1:0] led_state;
    logic                parity_err;
    logic                length_err;
    logic                last_ok;
    logic [NUM_LEDS-1:0] data;
    logic [1:0]          opcode;
    logic [NUM_LEDS-1:0] next_state;

    assign data   = sr[NUM_LEDS-1:0];
    assign opcode = sr[NUM_LEDS+1:NUM_LEDS];

    always_comb begin
        next_state = led_state;
        case (opcode)
            2'b00: next_state = data;
            2'b01: next_state = led_state | data;
            2'b10: next_state = led_state & ~data;
            2'b11: next_state = led_state ^ data;
            default: next_state = led_state;
        endcase
    end

    always_ff @(posedge jtag_tck or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            cnt        <= '0;
            led_state  <= RESET_PATTERN;
            parity_err <= 1'b0;
            length_err <= 1'b0;
            last_ok    <= 1'b0;
        end else if (jtag_sel) begin
            if (jtag_capture) begin
                sr         <= {last_ok, length_err, parity_err, led_state};
                cnt        <= '0;
                parity_err <= 1'b0;
                length_err <= 1'b0;
            end else if (jtag_shift) begin
                sr <= {jtag_tdi, sr[L-1:1]};
                if (cnt != CNT_SAT)
                    cnt <= cnt + 1'b1;
            end else if (jtag_update) begin
                // Parking the counter off L makes a repeated update a length error.
                cnt <= CNT_SAT;
                if (cnt != CNT_FULL) begin
                    length_err <= 1'b1;
                    last_ok    <= 1'b0;
                end else if (^sr) begin
                    parity_err <= 1'b1;
                    last_ok    <= 1'b0;
                end else begin
                    led_state <= next_state;
                    last_ok   <= 1'b1;
                end
            end
        end
    end

    assign jtag_tdo = sr[0];
    // Single inversion of a register output, so the pins cannot glitch.
    assign led = LED_ACTIVE_LOW ? ~led_state : led_state;
endmodule
